risc_rom_arbiter: RTL and testbench

- Shares the single combinational instruction ROM port between two requesters: instruction fetch (IF) and data read (DR, loads from code space).
- Pipelined: accepts one request per cycle, registers the ROM address, and returns registered read data with fixed 2-cycle latency.
- Provides a fetch flush for branch/goto redirects.
- Sits between the fetch stage / load unit and the ROM.

---
 rtl/risc_rom_arbiter.sv | 128 ++++++++++++
 tb/tb_risc_rom_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_rom_arbiter.sv
// Two-requester (IF / DR) arbiter for a shared combinational ROM port, 2-cycle registered read latency.
// Define RISC_ROM_ARB_RR_EN for round-robin arbitration; default is DR priority with an IF starvation guard.
module risc_rom_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_gnt,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_data,
   output logic              if_err,
   input  logic              dr_req,
   input  logic [ADDR_W-1:0] dr_addr,
   output logic              dr_gnt,
   output logic              dr_valid,
   output logic [DATA_W-1:0] dr_data,
   output logic              dr_err,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data
);

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DR = 1'b1
   } owner_t;

   logic   s1_valid;
   logic   s1_err;
   owner_t s1_owner;
   logic   s1_live;
   logic   if_pri;

   // NOTE: every output is assigned a default before the conditions, so no latch is inferred.
   always_comb begin
      if_gnt = 1'b0;
      dr_gnt = 1'b0;
      if (!reset) begin
         if (if_req && !if_flush && (!dr_req || if_pri))
            if_gnt = 1'b1;
         else if (dr_req)
            dr_gnt = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         rom_addr <= '0;
         s1_valid <= 1'b0;
         s1_owner <= OWN_IF;
         s1_err   <= 1'b0;
      end else begin
         s1_valid <= if_gnt || dr_gnt;
         if (if_gnt) begin
            rom_addr <= if_addr;
            s1_owner <= OWN_IF;
            s1_err   <= (if_addr[1:0] != 2'b00);
         end else if (dr_gnt) begin
            rom_addr <= dr_addr;
            s1_owner <= OWN_DR;
            s1_err   <= (dr_addr[1:0] != 2'b00);
         end
      end
   end

   // A redirect kills the IF access currently reading the ROM; DR traffic is untouched.
   assign s1_live = s1_valid && !(s1_owner == OWN_IF && if_flush);

   // NOTE: response data registers are reset too, since they are visible outputs that must read 0 after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         if_valid <= 1'b0;
         if_data  <= '0;
         if_err   <= 1'b0;
         dr_valid <= 1'b0;
         dr_data  <= '0;
         dr_err   <= 1'b0;
      end else begin
         if_valid <= s1_live && (s1_owner == OWN_IF);
         dr_valid <= s1_live && (s1_owner == OWN_DR);
         if (s1_live && s1_owner == OWN_IF) begin
            if_data <= s1_err ? '0 : rom_data;
            if_err  <= s1_err;
         end
         if (s1_live && s1_owner == OWN_DR) begin
            dr_data <= s1_err ? '0 : rom_data;
            dr_err  <= s1_err;
         end
      end
   end

`ifdef RISC_ROM_ARB_RR_EN
   owner_t rr_ptr;

   assign if_pri = (rr_ptr == OWN_IF);

   // The pointer always moves to the side that did not just win.
   always_ff @(posedge clk) begin
      if (reset)
         rr_ptr <= OWN_IF;
      else if (if_gnt)
         rr_ptr <= OWN_DR;
      else if (dr_gnt)
         rr_ptr <= OWN_IF;
   end
`else
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0] starve_cnt;

   assign if_pri = (starve_cnt == STARVE_LIM);

   always_ff @(posedge clk) begin
      if (reset)
         starve_cnt <= '0;
      else if (!if_req || if_gnt)
         starve_cnt <= '0;
      else if (starve_cnt != STARVE_LIM)
         starve_cnt <= starve_cnt + 4'd1;
   end
`endif

endmodule

// File: tb/tb_risc_rom_arbiter.sv
// Self-checking bench for risc_rom_arbiter: directed vector tables, hand sequences and a random run
// checked every cycle against a response-queue reference model.
module tb_risc_rom_arbiter;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              if_req, if_flush, dr_req;
   logic [ADDR_W-1:0] if_addr, dr_addr;
   logic              if_gnt, if_valid, if_err;
   logic              dr_gnt, dr_valid, dr_err;
   logic [DATA_W-1:0] if_data, dr_data, rom_data;
   logic [ADDR_W-1:0] rom_addr;

   risc_rom_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
      .if_valid(if_valid), .if_data(if_data), .if_err(if_err),
      .dr_req(dr_req), .dr_addr(dr_addr), .dr_gnt(dr_gnt),
      .dr_valid(dr_valid), .dr_data(dr_data), .dr_err(dr_err),
      .rom_addr(rom_addr), .rom_data(rom_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ a;
   endfunction

   assign rom_data = rom_word(rom_addr);

   typedef struct {
      logic        dr;
      logic [31:0] addr;
      int          due;
   } rsp_t;

   typedef struct {
      logic        ig, dg, iv, dv, ie, de;
      logic [31:0] id, dd, ra;
   } obs_t;

   typedef struct {
      logic        ireq;
      logic [31:0] iaddr;
      logic        iflush;
      logic        dreq;
      logic [31:0] daddr;
      logic        eig, edg, eiv, edv;
   } vec_t;

   rsp_t        q[$];
   vec_t        tbl[$];
   int          cyc;
   int          m_denied;
   logic        m_ptr;
   logic [31:0] m_rom_addr, m_if_data, m_dr_data;
   logic        m_if_err, m_dr_err;
   int          n_checks, n_fail;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // One clock cycle: drive inputs, sample at negedge, compare with the model, then advance it.
   task automatic step(input logic rst, input logic ireq, input logic [31:0] ia, input logic ifl,
                       input logic dreq, input logic [31:0] da, input bit chk, output obs_t o);
      logic eig, edg, ieff, eiv, edv;
      rsp_t keep[$];
      rsp_t r;
      reset = rst; if_req = ireq; if_addr = ia; if_flush = ifl; dr_req = dreq; dr_addr = da;
      @(negedge clk);
      ieff = ireq && !ifl;
`ifdef RISC_ROM_ARB_RR_EN
      eig = (ieff && dreq) ? (m_ptr == 1'b0) : ieff;
`else
      eig = ieff && (!dreq || m_denied == STARVE_MAX);
`endif
      edg = dreq && !eig;
      if (rst) begin
         eig = 1'b0;
         edg = 1'b0;
      end
      eiv = 1'b0;
      edv = 1'b0;
      foreach (q[i]) begin
         if (q[i].due == cyc) begin
            if (q[i].dr) begin
               edv = 1'b1;
               m_dr_err  = (q[i].addr[1:0] != 2'b00);
               m_dr_data = m_dr_err ? 32'h0 : rom_word(q[i].addr);
            end else begin
               eiv = 1'b1;
               m_if_err  = (q[i].addr[1:0] != 2'b00);
               m_if_data = m_if_err ? 32'h0 : rom_word(q[i].addr);
            end
         end
      end
      o.ig = if_gnt;  o.dg = dr_gnt;  o.iv = if_valid; o.dv = dr_valid;
      o.ie = if_err;  o.de = dr_err;  o.id = if_data;  o.dd = dr_data; o.ra = rom_addr;
      if (chk) begin
         check("model if_gnt",   o.ig, eig);
         check("model dr_gnt",   o.dg, edg);
         check("model if_valid", o.iv, eiv);
         check("model dr_valid", o.dv, edv);
         check("model if_data",  o.id, m_if_data);
         check("model dr_data",  o.dd, m_dr_data);
         check("model if_err",   o.ie, m_if_err);
         check("model dr_err",   o.de, m_dr_err);
         check("model rom_addr", o.ra, m_rom_addr);
      end
      if (rst) begin
         q.delete();
         m_denied = 0; m_ptr = 1'b0; m_rom_addr = '0;
         m_if_data = '0; m_dr_data = '0; m_if_err = 1'b0; m_dr_err = 1'b0;
      end else begin
         foreach (q[i])
            if (q[i].due > cyc && !(ifl && !q[i].dr && q[i].due == cyc + 1))
               keep.push_back(q[i]);
         q = keep;
         if (eig) begin
            r.dr = 1'b0; r.addr = ia; r.due = cyc + 2; q.push_back(r); m_rom_addr = ia;
         end
         if (edg) begin
            r.dr = 1'b1; r.addr = da; r.due = cyc + 2; q.push_back(r); m_rom_addr = da;
         end
         if (ireq && !eig) m_denied = (m_denied < STARVE_MAX) ? m_denied + 1 : STARVE_MAX;
         else              m_denied = 0;
         if (eig)      m_ptr = 1'b1;
         else if (edg) m_ptr = 1'b0;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic rst);
      obs_t o;
      step(rst, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, o);
   endtask

   task automatic add(input logic ireq, input logic [31:0] ia, input logic ifl, input logic dreq,
                      input logic [31:0] da, input logic eig, input logic edg, input logic eiv,
                      input logic edv);
      vec_t v;
      v.ireq = ireq; v.iaddr = ia; v.iflush = ifl; v.dreq = dreq; v.daddr = da;
      v.eig = eig; v.edg = edg; v.eiv = eiv; v.edv = edv;
      tbl.push_back(v);
   endtask

   task automatic run_table(input string name);
      obs_t o;
      foreach (tbl[i]) begin
         step(1'b0, tbl[i].ireq, tbl[i].iaddr, tbl[i].iflush, tbl[i].dreq, tbl[i].daddr, 1'b1, o);
         check({name, " if_gnt"},   o.ig, tbl[i].eig);
         check({name, " dr_gnt"},   o.dg, tbl[i].edg);
         check({name, " if_valid"}, o.iv, tbl[i].eiv);
         check({name, " dr_valid"}, o.dv, tbl[i].edv);
      end
      tbl.delete();
   endtask

   initial begin
      obs_t        o;
      logic        p_if, p_dr, ifl, rst;
      logic [31:0] p_ia, p_da;
      n_checks = 0; n_fail = 0; cyc = 0;
      q.delete();
      m_denied = 0; m_ptr = 1'b0; m_rom_addr = '0;
      m_if_data = '0; m_dr_data = '0; m_if_err = 1'b0; m_dr_err = 1'b0;

      // Reset: first cycle unchecked (power-up state), then outputs and grants must be 0.
      step(1'b1, 1'b1, 32'h4, 1'b0, 1'b1, 32'h8, 1'b0, o);
      step(1'b1, 1'b1, 32'h4, 1'b0, 1'b1, 32'h8, 1'b1, o);
      check("reset gnt", {o.ig, o.dg}, 2'b00);
      check("reset outputs", {o.iv, o.dv, o.ie, o.de, o.id, o.dd, o.ra}, '0);

      // Single IF read of 0x4.
      add(1, 32'h4, 0, 0, 0, 1, 0, 0, 0);
      add(0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 32'h0, 0, 0, 0, 0, 0, 1, 0);
      run_table("single_if");

      // Continuous contention with distinct addresses.
      idle(1'b1);
`ifdef RISC_ROM_ARB_RR_EN
      add(1, 32'h100, 0, 1, 32'h200, 1, 0, 0, 0);
      add(1, 32'h100, 0, 1, 32'h200, 0, 1, 0, 0);
      add(1, 32'h100, 0, 1, 32'h200, 1, 0, 1, 0);
      add(1, 32'h100, 0, 1, 32'h200, 0, 1, 0, 1);
      add(0, 32'h0,   0, 0, 32'h0,   0, 0, 1, 0);
      add(0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 1);
`else
      add(1, 32'h100, 0, 1, 32'h200, 0, 1, 0, 0);
      add(1, 32'h100, 0, 1, 32'h200, 0, 1, 0, 0);
      add(1, 32'h100, 0, 1, 32'h200, 0, 1, 0, 1);
      add(1, 32'h100, 0, 1, 32'h200, 0, 1, 0, 1);
      add(1, 32'h100, 0, 1, 32'h200, 1, 0, 0, 1);
      add(1, 32'h100, 0, 1, 32'h200, 0, 1, 0, 1);
      add(0, 32'h0,   0, 0, 32'h0,   0, 0, 1, 0);
      add(0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 1);
`endif
      run_table("contention");

      // Back-to-back IF stream.
      add(1, 32'h0, 0, 0, 0, 1, 0, 0, 0);
      add(1, 32'h4, 0, 0, 0, 1, 0, 0, 0);
      add(1, 32'h8, 0, 0, 0, 1, 0, 1, 0);
      add(1, 32'hC, 0, 0, 0, 1, 0, 1, 0);
      add(0, 32'h0, 0, 0, 0, 0, 0, 1, 0);
      add(0, 32'h0, 0, 0, 0, 0, 0, 1, 0);
      add(0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
      run_table("stream");

      // Flush while 0x14 is reading the ROM: 0x10 delivered, 0x14 dropped, DR granted in flush cycle.
      add(1, 32'h10, 0, 0, 32'h0,  1, 0, 0, 0);
      add(1, 32'h14, 0, 0, 32'h0,  1, 0, 0, 0);
      add(1, 32'h18, 1, 1, 32'h40, 0, 1, 1, 0);
      add(0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 0);
      add(0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 1);
      run_table("flush");

      // Misaligned DR read at 0x6.
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h6, 1'b1, o);
      check("misaligned dr_gnt", o.dg, 1'b1);
      idle(1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, o);
      check("misaligned response", {o.dv, o.de, o.dd}, {1'b1, 1'b1, 32'h0});

      // Reset mid-operation drops the in-flight IF access.
      step(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h30, 1'b1, o);
      step(1'b0, 1'b1, 32'h34, 1'b0, 1'b0, 32'h0,  1'b1, o);
      step(1'b1, 1'b1, 32'h38, 1'b1, 1'b1, 32'h3C, 1'b1, o);
      check("reset-cycle gnt", {o.ig, o.dg, o.dv}, 3'b001);
      step(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b1, o);
      check("post-reset quiet", {o.iv, o.dv, o.dd, o.ra}, '0);
      idle(1'b0);

      // Random traffic; requests are held until granted.
      p_if = 1'b0; p_dr = 1'b0; p_ia = '0; p_da = '0;
      for (int i = 0; i < 600; i++) begin
         if (!p_if && ($urandom % 4 != 0)) begin
            p_if = 1'b1;
            p_ia = $urandom_range(0, 1023);
            if ($urandom % 8 != 0) p_ia[1:0] = 2'b00;
         end
         if (!p_dr && ($urandom % 3 == 0)) begin
            p_dr = 1'b1;
            p_da = $urandom_range(0, 1023);
            if ($urandom % 6 != 0) p_da[1:0] = 2'b00;
         end
         ifl = ($urandom % 10 == 0);
         rst = ($urandom % 150 == 0);
         step(rst, p_if, p_ia, ifl, p_dr, p_da, 1'b1, o);
         if (o.ig) p_if = 1'b0;
         if (o.dg) p_dr = 1'b0;
      end
      idle(1'b0);
      idle(1'b0);
      idle(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
